// File: rtl/fetch_if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the RV32I core.
// One fetch outstanding at a time, a one-entry skid for decode stalls, and redirect/flush from execute.
`timescale 1ns/1ps
module fetch_if_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            id_valid,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [6:0]      id_opcode,
    input  logic            id_stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FULL,
        S_DROP
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic            id_valid_q, id_valid_d;
    logic [XLEN-1:0] id_instr_q, id_instr_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic            id_load;
    logic            can_load;

    assign imem_req  = (state_q == S_ISSUE);
    assign imem_addr = imem_req ? pc_q : '0;
    assign id_valid  = id_valid_q;
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;
    assign id_opcode = id_instr_q[6:0];
    assign can_load  = !id_valid_q || !id_stall;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        id_valid_d   = id_valid_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        id_load      = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_ISSUE;
            S_ISSUE: begin
                if (imem_gnt) begin
                    req_pc_d = pc_q;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    pc_d = req_pc_q + XLEN'(4);
                    if (can_load) begin
                        id_valid_d = 1'b1;
                        id_instr_d = imem_rdata;
                        id_pc_d    = req_pc_q;
                        id_load    = 1'b1;
                        state_d    = S_ISSUE;
                    end else begin
                        skid_valid_d = 1'b1;
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = req_pc_q;
                        state_d      = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (!id_stall) begin
                    id_valid_d   = 1'b1;
                    id_instr_d   = skid_instr_q;
                    id_pc_d      = skid_pc_q;
                    id_load      = 1'b1;
                    skid_valid_d = 1'b0;
                    state_d      = S_ISSUE;
                end
            end
            S_DROP: begin
                if (imem_rvalid) state_d = S_ISSUE;
            end
            default: state_d = S_IDLE;
        endcase

        if (id_valid_q && !id_stall && !id_load) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
            id_pc_d    = '0;
        end

        // A redirect while a stale fetch is still in flight (including one already in DROP) must keep draining it.
        if (redirect && state_q != S_IDLE) begin
            pc_d         = redirect_pc & ~XLEN'(3);
            id_valid_d   = 1'b0;
            id_instr_d   = NOP_INSTR;
            id_pc_d      = '0;
            skid_valid_d = 1'b0;
            if (((state_q == S_WAIT || state_q == S_DROP) && !imem_rvalid) ||
                (state_q == S_ISSUE && imem_gnt))
                state_d = S_DROP;
            else
                state_d = S_ISSUE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            id_valid_q   <= 1'b0;
            id_instr_q   <= NOP_INSTR;
            id_pc_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            id_valid_q   <= id_valid_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
        end
    end

endmodule
